// File: rtl/div_req_scheduler.sv
// Request FIFO feeding a single-outstanding divider, with an issue/wait FSM
// and a sticky watchdog that abandons divides whose result never returns.
module div_req_scheduler #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [DATA_WIDTH-1:0]  s_numerator,
    input  logic signed [DATA_WIDTH-1:0]  s_denominator,
    output logic                          div_in_valid,
    output logic [DATA_WIDTH-1:0]         div_numerator,
    output logic [DATA_WIDTH-1:0]         div_denominator,
    input  logic                          div_out_valid,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          busy,
    output logic                          timeout_flag,
    input  logic                          timeout_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                    state;
    logic [2*DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [CW-1:0]             count;
    logic [TW-1:0]             watchdog;
    logic                      push;
    logic                      pop;

    assign s_ready   = (count < CW'(DEPTH));
    assign push      = s_valid & s_ready;
    assign pop       = (state == ISSUE);
    assign occupancy = count;

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_numerator, s_denominator};
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue/wait FSM; the head is latched on entry to ISSUE and popped on exit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state           <= IDLE;
            div_in_valid    <= 1'b0;
            div_numerator   <= '0;
            div_denominator <= '0;
            busy            <= 1'b0;
            timeout_flag    <= 1'b0;
            watchdog        <= '0;
        end else begin
            div_in_valid <= 1'b0;
            if (timeout_clr) begin
                timeout_flag <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state                            <= ISSUE;
                        div_in_valid                     <= 1'b1;
                        {div_numerator, div_denominator} <= mem[rd_ptr];
                        busy                             <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    watchdog <= '0;
                end
                WAIT: begin
                    if (div_out_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        watchdog <= watchdog + TW'(1);
                        // A set in the same cycle as timeout_clr overrides the clear.
                        if (watchdog == TW'(TIMEOUT_CYCLES - 1)) begin
                            timeout_flag <= 1'b1;
                            state        <= IDLE;
                            busy         <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_req_scheduler.sv
// Randomized and directed bench for div_req_scheduler against a queue-based
// transaction model of the request/issue/wait behaviour.
module tb_div_req_scheduler;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 255;
    localparam int M_IDLE  = 0;
    localparam int M_ISSUE = 1;
    localparam int M_WAIT  = 2;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_numerator;
    logic [DW-1:0] s_denominator;
    logic          div_in_valid;
    logic [DW-1:0] div_numerator;
    logic [DW-1:0] div_denominator;
    logic          div_out_valid;
    logic [2:0]    occupancy;
    logic          busy;
    logic          timeout_flag;
    logic          timeout_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [2*DW-1:0] q[$];
    int              phase;
    int              wcnt;
    bit              m_flag;
    logic [DW-1:0]   m_num;
    logic [DW-1:0]   m_den;

    always #5 clk = ~clk;

    div_req_scheduler #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_numerator     (s_numerator),
        .s_denominator   (s_denominator),
        .div_in_valid    (div_in_valid),
        .div_numerator   (div_numerator),
        .div_denominator (div_denominator),
        .div_out_valid   (div_out_valid),
        .occupancy       (occupancy),
        .busy            (busy),
        .timeout_flag    (timeout_flag),
        .timeout_clr     (timeout_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase  = M_IDLE;
        wcnt   = 0;
        m_flag = 1'b0;
        m_num  = '0;
        m_den  = '0;
    endtask

    // Advance the model by one rising edge using the inputs presented at that edge.
    task automatic model_edge();
        bit              do_push;
        bit              to_set;
        logic [2*DW-1:0] pin;
        do_push = s_valid && (q.size() < int'(DEPTH));
        pin     = {s_numerator, s_denominator};
        to_set  = 1'b0;
        case (phase)
            M_IDLE: begin
                if (q.size() > 0) begin
                    phase          = M_ISSUE;
                    {m_num, m_den} = q[0];
                end
            end
            M_ISSUE: begin
                void'(q.pop_front());
                phase = M_WAIT;
                wcnt  = 0;
            end
            default: begin
                if (div_out_valid) begin
                    phase = M_IDLE;
                end else begin
                    wcnt++;
                    if (wcnt >= int'(TO)) begin
                        to_set = 1'b1;
                        phase  = M_IDLE;
                    end
                end
            end
        endcase
        if (timeout_clr) m_flag = 1'b0;
        if (to_set)      m_flag = 1'b1;
        if (do_push)     q.push_back(pin);
    endtask

    task automatic check_outputs();
        check("div_in_valid", 64'(div_in_valid), 64'(phase == M_ISSUE));
        check("busy",         64'(busy),         64'(phase != M_IDLE));
        check("occupancy",    64'(occupancy),    64'(q.size()));
        check("s_ready",      64'(s_ready),      64'(q.size() < int'(DEPTH)));
        check("timeout_flag", 64'(timeout_flag), 64'(m_flag));
        check("div_numerator",   64'(div_numerator),   64'(m_num));
        check("div_denominator", 64'(div_denominator), 64'(m_den));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        arst_n = 1'b1;
    endtask

    // Push n requests, holding each until accepted; divider responses are left alone.
    task automatic push_n(input int n);
        int            sent;
        int            guard;
        bit            acc;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        sent  = 0;
        guard = 0;
        a = $urandom;
        b = $urandom;
        while (sent < n && guard < 200) begin
            s_valid       = 1'b1;
            s_numerator   = a;
            s_denominator = b;
            acc = (q.size() < int'(DEPTH));
            cycle();
            if (acc) begin
                sent++;
                a = $urandom;
                b = $urandom;
            end
            guard++;
        end
        s_valid = 1'b0;
        check("push_n_sent", 64'(sent), 64'(n));
    endtask

    task automatic drain();
        int g;
        g = 0;
        s_valid = 1'b0;
        while ((q.size() != 0 || phase != M_IDLE) && g < 3000) begin
            div_out_valid = (phase == M_WAIT);
            cycle();
            g++;
        end
        div_out_valid = 1'b0;
        check("drain_left", 64'(q.size()), 64'd0);
    endtask

    initial begin
        arst_n        = 1'b0;
        s_valid       = 1'b0;
        s_numerator   = '0;
        s_denominator = '0;
        div_out_valid = 1'b0;
        timeout_clr   = 1'b0;
        model_reset();
        #2;
        apply_reset();

        // Single request: strobe two cycles after the push edge with those operands.
        s_valid       = 1'b1;
        s_numerator   = 32'h0030_0000;
        s_denominator = 32'h0010_0000;
        cycle();
        s_valid = 1'b0;
        check("lat_no_strobe_1", 64'(div_in_valid), 64'd0);
        cycle();
        check("lat_strobe_2", 64'(div_in_valid), 64'd1);
        check("single_num", 64'(div_numerator), 64'h0030_0000);
        check("single_den", 64'(div_denominator), 64'h0010_0000);
        repeat (4) cycle();
        check("single_busy_wait", 64'(busy), 64'd1);
        div_out_valid = 1'b1;
        cycle();
        div_out_valid = 1'b0;
        cycle();
        check("single_busy_done", 64'(busy), 64'd0);
        check("single_occ", 64'(occupancy), 64'd0);

        // Fill with divider stalled; sixth request must be held.
        push_n(5);
        check("fill_occ", 64'(occupancy), 64'd4);
        check("fill_ready", 64'(s_ready), 64'd0);
        s_valid       = 1'b1;
        s_numerator   = 32'h1234_5678;
        s_denominator = 32'h0000_0000;
        cycle();
        check("fill_held_occ", 64'(occupancy), 64'd4);
        s_valid = 1'b0;
        drain();

        // Push during the ISSUE cycle keeps occupancy at 2.
        push_n(2);
        check("simul_issue", 64'(div_in_valid), 64'd1);
        push_n(1);
        check("simul_occ", 64'(occupancy), 64'd2);
        drain();

        // Watchdog: never answer, flag sets and the next request issues.
        push_n(2);
        for (int i = 0; i < 300 && !m_flag; i++) cycle();
        check("wd_flag", 64'(timeout_flag), 64'd1);
        repeat (3) cycle();
        check("wd_next_busy", 64'(busy), 64'd1);
        timeout_clr = 1'b1;
        cycle();
        timeout_clr = 1'b0;
        check("wd_cleared", 64'(timeout_flag), 64'd0);
        drain();

        // Stray done pulse in IDLE with an empty FIFO.
        div_out_valid = 1'b1;
        cycle();
        div_out_valid = 1'b0;
        cycle();
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_issue", 64'(div_in_valid), 64'd0);

        // Reset mid-WAIT with three queued.
        push_n(4);
        cycle();
        check("rst_pre_occ", 64'(occupancy), 64'd3);
        apply_reset();
        check("rst_ready", 64'(s_ready), 64'd1);
        push_n(1);
        drain();

        // Randomized traffic including zero denominators and stray done pulses.
        for (int i = 0; i < 1500; i++) begin
            s_valid       = ($urandom_range(0, 2) != 0);
            s_numerator   = $urandom;
            s_denominator = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
            div_out_valid = ($urandom_range(0, 3) == 0);
            timeout_clr   = ($urandom_range(0, 31) == 0);
            cycle();
        end
        s_valid       = 1'b0;
        timeout_clr   = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
